// File: rtl/fpu_result_sink.sv
// Captures FPU results, converts them to IEEE-754 binary32 and buffers them in a show-ahead FIFO.
// Optional round-to-nearest-even is enabled by defining FPU_SINK_ROUND_EN; the default build truncates.
module fpu_result_sink #(
  parameter int DEPTH      = 4,
  parameter int EXP_REBIAS = 96
) (
  input  logic                     clock100KHz,
  input  logic                     reset,
  input  logic [31:0]              fpu_data_in,
  input  logic [3:0]               fpu_status_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic [3:0]               out_status,
  output logic                     out_inexact,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     drop_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] ST_OVERFLOW = 4'b0100;

  // Returns {inexact, ieee_word} for one FPU result.
  function automatic logic [32:0] convert(input logic [31:0] d, input logic [3:0] st);
    logic        s;
    logic [5:0]  e;
    logic [24:0] f;
    logic [7:0]  ie;
    logic [22:0] m;
    logic        g;
    logic        sk;
    logic        inc;
    logic [23:0] mr;
    s  = d[31];
    e  = d[30:25];
    f  = d[24:0];
    ie = {2'b00, e} + EXP_REBIAS[7:0];
    m  = f[24:2];
    g  = f[1];
    sk = f[0];
`ifdef FPU_SINK_ROUND_EN
    inc = g & (sk | m[0]);
`else
    inc = 1'b0;
`endif
    mr = {1'b0, m} + {23'd0, inc};
    // Mantissa carry-out wraps the fraction to zero and bumps the exponent.
    if (mr[23])
      ie = ie + 8'd1;
    if (st == ST_OVERFLOW)
      convert = {1'b0, s, 8'hFF, 23'h0};
    else if (e == 6'd0 && f == 25'd0)
      convert = {1'b0, s, 31'h0};
    else
      convert = {g | sk, s, ie, mr[22:0]};
  endfunction

  logic [35:0]   last_cap;
  logic          cap;
  logic [32:0]   conv_res;
  logic          conv_valid;
  logic [31:0]   conv_data;
  logic [3:0]    conv_status;
  logic          conv_inexact;

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic [36:0]   head;

  // Stage C: capture detection and conversion
  assign cap      = ({fpu_status_in, fpu_data_in} != last_cap) && (fpu_status_in != 4'b0000);
  assign conv_res = convert(fpu_data_in, fpu_status_in);

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      last_cap   <= '0;
      conv_valid <= 1'b0;
    end else begin
      conv_valid <= cap;
      if (cap)
        last_cap <= {fpu_status_in, fpu_data_in};
    end
  end

  always_ff @(posedge clock100KHz) begin
    if (cap) begin
      conv_data    <= conv_res[31:0];
      conv_status  <= fpu_status_in;
      conv_inexact <= conv_res[32];
    end
  end

  // Stage F: FIFO write and show-ahead read
  assign full  = (count == CW'(DEPTH));
  assign push  = conv_valid;
  assign pop   = out_valid & out_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clock100KHz) begin
    if (wr_en)
      mem[wr_ptr] <= {conv_inexact, conv_status, conv_data};
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        count <= count + 1'b1;
      else if (pop && !wr_en)
        count <= count - 1'b1;
      if (push && full && !pop)
        drop_flag <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign out_valid   = (count != '0);
  assign out_data    = out_valid ? head[31:0]  : 32'd0;
  assign out_status  = out_valid ? head[35:32] : 4'd0;
  assign out_inexact = out_valid ? head[36]    : 1'b0;
  assign fifo_count  = count;

endmodule

// File: doc/fpu_result_sink.md
# fpu_result_sink

Downstream stage of the floating-point unit. It watches the FPU result bus (`fpu_data_in`, `fpu_status_in`) and captures each new result. Each captured result is converted from the FPU's internal format (1 sign, 6-bit exponent with bias 31, 25-bit fraction with hidden 1) to IEEE-754 binary32. Converted results are buffered in a small FIFO and handed to the consumer over a valid/ready handshake.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `EXP_REBIAS`, 96, added to the FPU exponent to form the IEEE exponent (127 − 31)
- `clock100KHz`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- `fpu_data_in`  in  32  FPU result {sign, exp[5:0], frac[24:0]}
- `fpu_status_in`  in  4  FPU status: 0001 exact, 0100 overflow, 1000 underflow, 0000 no result yet
- `out_ready`  in  1  consumer accepts the head entry
- `out_valid`  out  1  FIFO non-empty
- `out_data`  out  32  IEEE-754 binary32 head entry
- `out_status`  out  4  FPU status captured with the head entry
- `out_inexact`  out  1  head entry lost nonzero fraction bits in conversion
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries
- `drop_flag`  out  1  sticky: a capture was discarded because the FIFO was full

## Operation
- Capture detection: a new result is `{fpu_status_in, fpu_data_in}` ≠ `last_cap` AND `fpu_status_in` ≠ 0000. On capture, `last_cap` takes the new value. Repeated identical results are one result by definition and are not re-captured.
- Conversion, stage C, is combinational from the inputs. Results are registered into `conv_*` with `conv_valid`.
  - Status 0100 (overflow): output ±Inf, i.e. {s, 8'hFF, 23'h0}, inexact = 0.
  - exp = 0 and frac = 0: output ±0.
  - Otherwise: IEEE exponent = exp + `EXP_REBIAS` in 8 bits, range 96..159, never overflows. Mantissa = frac[24:2], guard = frac[1], sticky = frac[0], inexact = guard | sticky.
  - Rounding as per Configuration. A mantissa carry-out (all ones + 1) gives mantissa 0 and exponent + 1.
- Stage F: if `conv_valid`, the registered entry {data, status, inexact} is pushed into the FIFO.
- FIFO: circular buffer with `wr_ptr`, `rd_ptr`, and `count`. Show-ahead: `out_*` always reflects the head entry. A pop occurs when `out_valid & out_ready`.
- Full-FIFO push without a simultaneous pop: the entry is discarded, `drop_flag` ← 1, and `count` is unchanged.
- Full FIFO with push and pop in the same cycle: both take effect and `count` is unchanged.
- Empty FIFO with push only: `count` ← 1. `out_ready` while empty is ignored.
- Pointers wrap modulo `DEPTH`.

## Timing
- Reset (synchronous, active-high, one clock): `out_valid`=0, `out_data`=0, `out_status`=0, `out_inexact`=0, `fifo_count`=0, `drop_flag`=0. Also `last_cap`=0, `conv_valid`=0, and pointers = 0.
- Reset mid-operation discards the FIFO contents and any in-flight `conv` entry. The first non-zero-status input after reset is always captured.
- Latency: input changes before edge k → `conv` registered at edge k → FIFO write at edge k+1 → `out_valid`=1 after edge k+1. That is 2 cycles from input to output.
- Throughput: one capture per cycle. The FPU produces at most one result per 5 cycles, so a DEPTH of 4 absorbs a stalled consumer for at least 20 cycles.
- `out_data`, `out_status`, and `out_inexact` are stable while `out_valid` = 1 and `out_ready` = 0.
- `drop_flag` is cleared only by reset.

## Configuration
- `FPU_SINK_ROUND_EN` defined: round-to-nearest-even. Increment the mantissa when guard & (sticky | mantissa[0]).
- `FPU_SINK_ROUND_EN` undefined: truncate, so the mantissa is frac[24:2]. `out_inexact` is still reported.

## Test plan
- Reset, then input 0x3E000000 with status 0001 → after 2 cycles `out_valid`=1, `out_data`=0x3F800000, inexact=0, `fifo_count`=1. Holding the input constant 10 cycles → `fifo_count` stays 1.
- Input 0x3E000003 with status 0001 and ROUND_EN defined → `out_data`=0x3F800001, inexact=1. Same input without the macro → 0x3F800000.
- Input 0x3FFFFFFF with status 0001 and ROUND_EN defined → mantissa carry, `out_data`=0x40000000. Status 0100 with sign 1 → `out_data`=0xFF800000.
- `out_ready`=0 and 5 distinct results → `fifo_count`=4, `drop_flag`=1. The 5th result is absent when draining, and the 4 entries pop in order.
- FIFO full, a new result arriving at the F stage in the same cycle as `out_ready`=1 → the entry is accepted, `fifo_count` stays 4, and `drop_flag` is unchanged.
- Reset asserted for 1 cycle while `count`=3 → `out_valid`=0 and `fifo_count`=0 the next cycle. Re-presenting the previously captured input → captured again.
